grid_led_scan: RTL
==================

Name: grid_led_scan

Overview:
- Downstream consumer of the 8x8 Life datapath's registered 64-bit Grid_Evolved.
- Captures each new generation and double-buffers it, so the displayed image never tears mid-frame.
- Drives an 8x8 LED matrix by row multiplexing, one-hot row select plus column data.
- Reports the generation count and an extinct flag to the top level.

Parameters:
ROW_CYCLES  1000  clocks each row stays lit; legal range 2..65535
GEN_W       16    width of the generation counter

Ports:
clk         input   1      system clock, rising edge
reset       input   1      asynchronous, active-high reset
grid_in     input   64     generation from the evolve flop; cell (r,c) = grid_in[8*r + c]
grid_valid  input   1      one-cycle pulse: grid_in holds a new generation this cycle
row_sel     output  8      one-hot row drive, active-high; bit r lights row r
col_out     output  8      column data for the lit row; bit c = cell (r,c)
frame_start output  1      one-cycle pulse when row 0 begins
gen_count   output  GEN_W  number of accepted generations, saturating
extinct     output  1      1 when the displayed grid is all zero
stable      output  1      still-life flag (see Optional Feature)

Behaviour:
- Reset (async, active-high) forces:
  - prescale = 0, row = 0, row_sel = 8'h01, col_out = 8'h00
  - disp_reg = 0, pend_reg = 0, pend_flag = 0
  - gen_count = 0, frame_start = 0, extinct = 1, stable = 0
- Prescaler:
  - Counts 0..ROW_CYCLES-1, then wraps to 0.
  - The wrap cycle is row_tc.
- Row counter:
  - Advances only on row_tc: 0->1->...->7->0.
  - frame_tc = row_tc while row == 7.
- Row outputs:
  - row_sel and col_out are registered and update on the edge where the row changes.
  - row_sel = 1 << row; col_out = disp_reg[8*row +: 8] for the new row.
  - They never glitch between row_tc edges.
- frame_start:
  - Registered; 1 for exactly one cycle, the first cycle after the row becomes 0.
  - Not asserted on the first frame after reset.
- Capture:
  - grid_valid on a cycle that is not frame_tc: pend_reg <= grid_in, pend_flag <= 1.
  - A later grid_valid in the same frame overwrites pend_reg; latest wins, earlier grids are dropped from display.
- Frame swap at frame_tc:
  - If grid_valid is 1 that cycle: disp_reg <= grid_in (bypass).
  - Else if pend_flag: disp_reg <= pend_reg.
  - Else: disp_reg holds.
  - pend_flag <= 0 in all three cases.
  - Row 0 of the new frame shows the new disp_reg.
- Display latency: a generation is visible on col_out within one frame (8*ROW_CYCLES clocks) plus one clock.
- gen_count:
  - +1 on every grid_valid, including ones superseded before display.
  - Saturates at all-ones.
- extinct = (disp_reg == 0). It is decoded from a register and changes only at frame swaps or reset.
- Reset mid-frame: row_sel returns to 8'h01 and the pending grid is discarded.
- Control:
  - No FSM states beyond the two counters and pend_flag.
  - pend_flag is a two-state machine: EMPTY -> FULL on capture; FULL -> EMPTY at frame_tc.

Optional Feature:
- Macro: GRID_STILL_DETECT_EN
- Defined:
  - prev_reg (64 bits, reset 0) is loaded with grid_in on every grid_valid.
  - stable <= (grid_in == prev_reg) on each grid_valid and holds between pulses.
  - A changing grid clears stable.
  - The first grid_valid after reset compares against 0; an all-zero first grid sets stable.
- Not defined:
  - stable is tied to 0 and prev_reg is not built.
  - The port stays present.

Test Plan (ROW_CYCLES = 4):
- Reset, then run 32 clocks -> row_sel steps 01,02,04,...,80,01, each held 4 clocks; col_out = 0; extinct = 1; frame_start pulses once, at the return to row 0.
- grid_valid with grid_in = 64'h0412_6424_0034_3C28 mid-row 2 -> no change until frame_tc. Next frame col_out per row is 28,3C,34,00,24,64,12,04; extinct = 0; gen_count = 1.
- Two grid_valid pulses in one frame (64'hFF, then 64'hFF00) -> next frame shows row0 = 00, row1 = FF; gen_count = 2.
- grid_valid exactly on frame_tc with grid_in = 64'h8000_0000_0000_0001 -> row 0 of the next frame shows col_out = 01, row 7 shows 80.
- Assert reset during row 5 with a pending grid -> row_sel = 01 asynchronously, col_out = 0, gen_count = 0; the pending grid never appears.
- GRID_STILL_DETECT_EN defined, two grid_valid with 64'h0000_0018_1800_0000 (block) -> stable = 1 after the second; then 64'h0 -> stable = 0. Undefined build: stable = 0 throughout.

Source files
------------

// File: rtl/grid_led_scan.sv
// Double-buffered 8x8 LED row-multiplex driver fed by the Life evolve flop.
// Optional still-life detection is built when GRID_STILL_DETECT_EN is defined.
module grid_led_scan #(
  parameter int ROW_CYCLES = 1000,
  parameter int GEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      grid_in,
  input  logic             grid_valid,
  output logic [7:0]       row_sel,
  output logic [7:0]       col_out,
  output logic             frame_start,
  output logic [GEN_W-1:0] gen_count,
  output logic             extinct,
  output logic             stable
);

  // Handshake: grid_valid is a one-cycle push with no back-pressure; every
  // pulse is accepted and counted, and only the latest grid of a frame is shown.

  localparam int PW = 16;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_t;

  pend_state_t      pend_state;
  pend_state_t      pend_nxt;
  logic             pend_flag;

  logic [PW-1:0]    prescale;
  logic [PW-1:0]    prescale_nxt;
  logic [2:0]       row;
  logic [2:0]       row_nxt;
  logic             row_tc;
  logic             frame_tc;

  logic [63:0]      disp_reg;
  logic [63:0]      disp_nxt;
  logic [63:0]      pend_reg;
  logic [GEN_W-1:0] gen_nxt;

  assign pend_flag = (pend_state == PEND_FULL);
  assign row_tc    = (prescale == PW'(ROW_CYCLES - 1));
  assign frame_tc  = row_tc && (row == 3'd7);

  always_comb begin
    prescale_nxt = prescale + PW'(1);
    row_nxt      = row;
    disp_nxt     = disp_reg;
    pend_nxt     = pend_state;
    gen_nxt      = gen_count;

    if (row_tc) begin
      prescale_nxt = '0;
      row_nxt      = row + 3'd1;
    end

    // A grid arriving on the swap cycle bypasses the pending buffer.
    if (frame_tc) begin
      pend_nxt = PEND_EMPTY;
      if (grid_valid) begin
        disp_nxt = grid_in;
      end else if (pend_flag) begin
        disp_nxt = pend_reg;
      end
    end else if (grid_valid) begin
      pend_nxt = PEND_FULL;
    end

    if (grid_valid && (gen_count != {GEN_W{1'b1}})) begin
      gen_nxt = gen_count + GEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_state <= PEND_EMPTY;
    end else begin
      pend_state <= pend_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale    <= '0;
      row         <= 3'd0;
      row_sel     <= 8'h01;
      col_out     <= 8'h00;
      disp_reg    <= '0;
      pend_reg    <= '0;
      gen_count   <= '0;
      frame_start <= 1'b0;
      extinct     <= 1'b1;
    end else begin
      prescale    <= prescale_nxt;
      row         <= row_nxt;
      disp_reg    <= disp_nxt;
      gen_count   <= gen_nxt;
      frame_start <= frame_tc;

      // Row outputs use disp_nxt so row 0 of a new frame shows the new image.
      if (row_tc) begin
        row_sel <= 8'h01 << row_nxt;
        col_out <= disp_nxt[{row_nxt, 3'b000} +: 8];
      end

      if (grid_valid && !frame_tc) begin
        pend_reg <= grid_in;
      end

      if (frame_tc) begin
        extinct <= (disp_nxt == 64'd0);
      end
    end
  end

`ifdef GRID_STILL_DETECT_EN
  logic [63:0] prev_reg;
  logic        stable_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg <= '0;
      stable_q <= 1'b0;
    end else if (grid_valid) begin
      prev_reg <= grid_in;
      stable_q <= (grid_in == prev_reg);
    end
  end

  assign stable = stable_q;
`else
  assign stable = 1'b0;
`endif

endmodule
